if_fetch_stage: RTL

- Instruction-fetch stage of the RISC-V pipeline: owns the PC, issues requests to instruction memory and holds the fetched word in the IF/ID register.
- Feeds the decoder: id_opcode_o drives the decoder opcode input; id_instr_o and id_pc_o go to register-file read and immediate generation.
- Accepts stall from the hazard unit and redirect (taken branch) from EX.

---
 rtl/rv_pkg.sv | 25 ++
 rtl/if_id_reg.sv | 51 +++++
 rtl/if_fetch_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V pipeline definitions: opcodes, bubble instruction and fetch FSM encoding.
// Imported by the fetch stage and its IF/ID register.
package rv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a new instruction, insert a bubble, or hold.
// Bubble wins over load; an invalid entry always carries the NOP word.
module if_id_reg #(
  parameter logic [31:0] NOP_VAL = rv_pkg::NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (bubble_i) begin
      valid_d = 1'b0;
      instr_d = NOP_VAL;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0;
      instr_q <= NOP_VAL;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch_stage.sv
// RISC-V instruction fetch: owns the PC, drives instruction memory, fills IF/ID.
// Zero-wait memory gives one instruction per cycle; a stalled response parks in a skid buffer.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o,
  output logic [6:0]  id_opcode_o
);

  import rv_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic [31:0]  skid_q, skid_d;
  logic [31:0]  target;
  logic         ifid_load, ifid_bubble;
  logic [31:0]  ifid_instr;

  assign target = align_pc(redirect_pc_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      pend_pc_q <= RESET_PC;
      skid_q    <= NOP_INSTR;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      skid_q    <= skid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    skid_d    = skid_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect_i) pc_d = target;
      end
      FETCH: begin
        if (redirect_i) begin
          if (imem_ready_i) begin
            pc_d = target;
          end else begin
            pend_pc_d = target;
            state_d   = DRAIN;
          end
        end else if (imem_ready_i) begin
          if (stall_i) begin
            skid_d  = imem_rdata_i;
            state_d = HOLD;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      HOLD: begin
        if (redirect_i) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (!stall_i) begin
          pc_d    = pc_q + 32'd4;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        // The abandoned access must complete before the new address may be issued.
        if (redirect_i) pend_pc_d = target;
        if (imem_ready_i) begin
          pc_d    = redirect_i ? target : pend_pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req_o  = 1'b0;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_instr  = imem_rdata_i;
    case (state_q)
      IDLE: ifid_bubble = redirect_i;
      FETCH: begin
        imem_req_o = 1'b1;
        if (redirect_i)                     ifid_bubble = 1'b1;
        else if (imem_ready_i && !stall_i)  ifid_load   = 1'b1;
        else if (!imem_ready_i && !stall_i) ifid_bubble = 1'b1;
      end
      HOLD: begin
        ifid_instr = skid_q;
        if (redirect_i)    ifid_bubble = 1'b1;
        else if (!stall_i) ifid_load   = 1'b1;
      end
      DRAIN: begin
        imem_req_o  = 1'b1;
        ifid_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  assign imem_addr_o = pc_q;

  if_id_reg #(.NOP_VAL(NOP_INSTR)) u_if_id_reg (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .pc_i     (pc_q),
    .instr_i  (ifid_instr),
    .valid_o  (id_valid_o),
    .pc_o     (id_pc_o),
    .instr_o  (id_instr_o)
  );

  assign id_opcode_o = id_instr_o[6:0];

endmodule
